jtframe_clk_lockmon: RTL and testbench

- Clock-consumer companion to the frame PLL block: it observes one PLL output and produces a `locked` indication from measured frequency, independent of the PLL's own lock flag.
- Runs on a single reference clock and samples the monitored clock as an asynchronous data input.
- Counts the monitored clock's rising edges over a fixed gate window and compares each count against a programmed range.
- Asserts `locked` after a run of consecutive in-range windows; used in the clocking wrapper to hold game/SDRAM reset until clocks are verified.

---
 rtl/jtframe_clk_lockmon.sv | 132 +++++++++++++
 tb/tb_jtframe_clk_lockmon.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/jtframe_clk_lockmon.sv
// Frequency-based lock monitor: counts rising edges of an asynchronous clock over a
// fixed reference-clock window and asserts locked after enough consecutive in-range windows.
module jtframe_clk_lockmon #(
    parameter int unsigned GATE     = 1024,
    parameter int unsigned CW       = 16,
    parameter int unsigned EXP_MIN  = 126,
    parameter int unsigned EXP_MAX  = 130,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          meas_clk,
    output logic          locked,
    output logic [CW-1:0] count,
    output logic          count_vld,
    output logic          fail
);

    localparam int unsigned GW = (GATE > 1) ? $clog2(GATE) : 1;
    localparam int unsigned LW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic [GW-1:0] gate_q, gate_d;
    logic [CW-1:0] edge_q, edge_d;
    logic [LW-1:0] good_q, good_d;
    logic [CW-1:0] count_q, count_d;
    logic          vld_q, vld_d;
    logic          fail_q, fail_d;
    logic          locked_q, locked_d;

    logic          edge_c;
    logic [CW-1:0] edge_inc_c;
    logic [CW-1:0] win_cnt_c;
    logic [LW-1:0] good_inc_c;
    logic          in_range_c;

    // Edge counter value including any edge detected this cycle, saturating at all-ones
    always_comb begin
        edge_c     = s2_q & ~s3_q;
        edge_inc_c = (edge_q == {CW{1'b1}}) ? edge_q : edge_q + CW'(1);
        win_cnt_c  = edge_c ? edge_inc_c : edge_q;
        in_range_c = (32'(win_cnt_c) >= EXP_MIN) && (32'(win_cnt_c) <= EXP_MAX);
        good_inc_c = (good_q >= LW'(LOCK_CNT)) ? good_q : good_q + LW'(1);
    end

    // Window sequencing, evaluation and lock state
    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        edge_d   = edge_q;
        good_d   = good_q;
        count_d  = count_q;
        vld_d    = 1'b0;
        fail_d   = 1'b0;
        locked_d = locked_q;

        if (!en) begin
            state_d  = IDLE;
            gate_d   = '0;
            edge_d   = '0;
            good_d   = '0;
            locked_d = 1'b0;
        end else begin
            if (state_q == IDLE) begin
                state_d = MEASURE;
            end
            edge_d = win_cnt_c;
            gate_d = gate_q + GW'(1);
            if (gate_q == GW'(GATE - 1)) begin
                // Terminal cycle: publish this window and start the next one with a clean count
                gate_d  = '0;
                edge_d  = '0;
                count_d = win_cnt_c;
                vld_d   = 1'b1;
                if (in_range_c) begin
                    good_d = good_inc_c;
                    if (good_inc_c == LW'(LOCK_CNT)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end else begin
                    good_d   = '0;
                    fail_d   = 1'b1;
                    state_d  = MEASURE;
                    locked_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            gate_q   <= '0;
            edge_q   <= '0;
            good_q   <= '0;
            count_q  <= '0;
            vld_q    <= 1'b0;
            fail_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= meas_clk;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            gate_q   <= gate_d;
            edge_q   <= edge_d;
            good_q   <= good_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            fail_q   <= fail_d;
            locked_q <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign count     = count_q;
    assign count_vld = vld_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_jtframe_clk_lockmon.sv
// Directed bench for jtframe_clk_lockmon: steady lock, clock loss, over-frequency,
// single bad window, enable/reset handling and edge-counter saturation (CW=6 instance).
`timescale 1ns/1ps
module tb_jtframe_clk_lockmon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        meas_clk = 1'b0;
    logic        meas_run = 1'b1;
    int          half = 40;

    logic        locked, count_vld, fail;
    logic [15:0] count;
    logic        locked6, count_vld6, fail6;
    logic [5:0]  count6;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int last_vld = 0;

    jtframe_clk_lockmon dut (
        .clk(clk), .rst_n(rst_n), .en(en), .meas_clk(meas_clk),
        .locked(locked), .count(count), .count_vld(count_vld), .fail(fail)
    );

    jtframe_clk_lockmon #(.CW(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .meas_clk(meas_clk),
        .locked(locked6), .count(count6), .count_vld(count_vld6), .fail(fail6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitored clock: rises at 2 ns + k*2*half, phase kept while stopped
    initial begin
        #2;
        forever begin
            meas_clk = meas_run;
            #(half);
            meas_clk = 1'b0;
            #(half);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Wait for the next count_vld (bounded), check cadence and window results,
    // then check the pulses on the following cycle.
    task automatic window(input string tag, input int lo, input int hi,
                          input logic exp_fail, input logic exp_locked, input logic chk6);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!count_vld && n < 2000);
        chk({tag, "_gap"}, 32'(cyc - last_vld), 32'd1024);
        last_vld = cyc;
        chk({tag, "_range"}, 32'(int'(count) >= lo && int'(count) <= hi), 32'd1);
        chk({tag, "_fail"}, 32'(fail), 32'(exp_fail));
        chk({tag, "_locked"}, 32'(locked), 32'(exp_locked));
        if (chk6) begin
            chk({tag, "_vld6"}, 32'(count_vld6), 32'd1);
            chk({tag, "_count6"}, 32'(count6), 32'd63);
            chk({tag, "_fail6"}, 32'(fail6), 32'd1);
            chk({tag, "_locked6"}, 32'(locked6), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_vld_pulse"}, 32'(count_vld), 32'd0);
        chk({tag, "_fail_pulse"}, 32'(fail), 32'd0);
    endtask

    task automatic align(input int ph);
        while (($time % 80) != ph) @(negedge clk);
    endtask

    initial begin
        int   saved;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_vld", 32'(count_vld), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);

        // Released but disabled: stays idle
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            seen = seen | count_vld | fail | locked;
        end
        chk("idle_quiet", 32'(seen), 32'd0);

        // Steady 80 ns clock: lock on 4th window, held for 20 windows
        align(70);
        en = 1'b1;
        last_vld = cyc;
        for (int w = 1; w <= 20; w++)
            window($sformatf("steady%0d", w), 127, 128, 1'b0, w >= 4, 1'b1);

        // Clock loss starting at a window boundary
        meas_run = 1'b0;
        window("loss", 0, 0, 1'b1, 1'b0, 1'b0);
        meas_run = 1'b1;
        for (int w = 1; w <= 4; w++)
            window($sformatf("restore%0d", w), 127, 128, 1'b0, w == 4, 1'b0);

        // One stretched period (3 us without edges)
        meas_run = 1'b0;
        #3000;
        meas_run = 1'b1;
        window("bad", 0, 125, 1'b1, 1'b0, 1'b0);
        for (int w = 1; w <= 4; w++)
            window($sformatf("relock%0d", w), 127, 128, 1'b0, w == 4, 1'b0);

        // Over-frequency: 40 ns period
        half = 20;
        for (int w = 1; w <= 4; w++)
            window($sformatf("fast%0d", w), 255, 256, 1'b1, 1'b0, 1'b0);
        half = 40;
        for (int w = 1; w <= 4; w++)
            window($sformatf("slow%0d", w), 127, 128, 1'b0, w == 4, 1'b0);

        // Enable drop while locked
        repeat (300) @(negedge clk);
        saved = int'(count);
        en = 1'b0;
        @(negedge clk);
        chk("en_locked", 32'(locked), 32'd0);
        chk("en_count_held", 32'(count), 32'(saved));
        seen = count_vld;
        repeat (99) begin
            @(negedge clk);
            seen = seen | count_vld | fail | locked;
        end
        align(70);
        chk("en_quiet", 32'(seen), 32'd0);
        chk("en_count_held2", 32'(count), 32'(saved));
        en = 1'b1;
        last_vld = cyc;
        for (int w = 1; w <= 4; w++)
            window($sformatf("reen%0d", w), 127, 128, 1'b0, w == 4, 1'b0);

        // Short asynchronous reset pulse mid-window while locked
        repeat (200) @(negedge clk);
        align(50);
        #1 rst_n = 1'b0;
        #1;
        chk("ares_locked", 32'(locked), 32'd0);
        chk("ares_count", 32'(count), 32'd0);
        chk("ares_vld", 32'(count_vld), 32'd0);
        chk("ares_fail", 32'(fail), 32'd0);
        #2 rst_n = 1'b1;
        last_vld = cyc;
        window("post_rst", 127, 128, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
